// File: rtl/lr35902_sio_pkg.sv
// Shared constants for the LR35902 serial I/O port (SB/SC registers).
package lr35902_sio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_XFER_INT = 2'd1,
    ST_XFER_EXT = 2'd2
  } sio_state_t;

  localparam logic       ADR_SB     = 1'b0;
  localparam logic       ADR_SC     = 1'b1;
  localparam logic [7:0] SC_RD_MASK = 8'h7E;

endpackage

// File: rtl/sio_edge_sync.sv
// Two-flop synchronizer for the external shift clock, with single-cycle
// rise/fall pulses taken from the synchronized value.
module sio_edge_sync (
  input  logic clk,
  input  logic n_reset,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_q    = r_sync;
  assign o_rise =  r_sync & ~r_prev;
  assign o_fall = ~r_sync &  r_prev;

endmodule

// File: rtl/lr35902_sio.sv
// LR35902 serial link: SB shift register, SC control, internal 8192 Hz
// shift clock or external synchronized clock, one-cycle completion irq.
module lr35902_sio
  import lr35902_sio_pkg::*;
#(
  parameter int HALF_PERIOD = 256
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       adr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       read,
  input  logic       write,
  output logic       irq,
  input  logic       sin,
  output logic       sout,
  input  logic       sck_in,
  output logic       sck_out,
  output logic       sck_oe
);

  localparam int DW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [DW-1:0] DIV_TC = DW'(HALF_PERIOD - 1);

  sio_state_t    r_state;
  logic [7:0]    r_sb;
  logic          r_sc7;
  logic          r_sc0;
  logic [2:0]    r_bitcnt;
  logic [DW-1:0] r_div;
  logic          r_sout;
  logic          r_sck_out;
  logic          r_irq;

  logic w_ext_q;
  logic w_ext_rise;
  logic w_ext_fall;
  logic w_div_tc;
  logic w_rise_evt;
  logic w_fall_evt;
  logic w_done;
  logic w_idle_like;
  logic w_unused_read;

  assign w_unused_read = read;

  sio_edge_sync u_sync (
    .clk     (clk),
    .n_reset (n_reset),
    .i_d     (sck_in),
    .o_q     (w_ext_q),
    .o_rise  (w_ext_rise),
    .o_fall  (w_ext_fall)
  );

  always_comb begin
    w_div_tc    = (r_div == DIV_TC);
    w_rise_evt  = 1'b0;
    w_fall_evt  = 1'b0;
    if (r_state == ST_XFER_INT) begin
      w_rise_evt = w_div_tc & ~r_sck_out;
      w_fall_evt = w_div_tc &  r_sck_out;
    end else if (r_state == ST_XFER_EXT) begin
      w_rise_evt = w_ext_rise;
      w_fall_evt = w_ext_fall;
    end
    w_done      = w_rise_evt & (r_bitcnt == 3'd7);
    // The completion cycle accepts register writes as if already idle.
    w_idle_like = (r_state == ST_IDLE) | w_done;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state   <= ST_IDLE;
      r_sb      <= '0;
      r_sc7     <= 1'b0;
      r_sc0     <= 1'b0;
      r_bitcnt  <= '0;
      r_div     <= '0;
      r_sout    <= 1'b1;
      r_sck_out <= 1'b1;
      r_irq     <= 1'b0;
    end else begin
      r_irq <= 1'b0;

      if (r_state == ST_XFER_INT) begin
        if (w_div_tc) begin
          r_div     <= '0;
          r_sck_out <= ~r_sck_out;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end

      if (w_fall_evt)
        r_sout <= r_sb[7];
      if (w_rise_evt) begin
        r_sb     <= {r_sb[6:0], sin};
        r_bitcnt <= r_bitcnt + 1'b1;
      end

      if (w_done) begin
        r_state   <= ST_IDLE;
        r_sc7     <= 1'b0;
        r_irq     <= 1'b1;
        r_sck_out <= 1'b1;
      end

      // Write handling comes last so a completion-cycle write overrides the final shift.
      if (write) begin
        if (adr == ADR_SB) begin
          if (w_idle_like)
            r_sb <= din;
        end else if (w_idle_like) begin
          r_sc0 <= din[0];
          if (din[7]) begin
            r_sc7     <= 1'b1;
            r_bitcnt  <= '0;
            r_div     <= '0;
            r_sck_out <= 1'b1;
            r_state   <= din[0] ? ST_XFER_INT : ST_XFER_EXT;
          end
        end else if (!din[7]) begin
          r_sc0     <= din[0];
          r_sc7     <= 1'b0;
          r_div     <= '0;
          r_sck_out <= 1'b1;
          r_state   <= ST_IDLE;
        end
      end
    end
  end

  always_comb begin
    dout = r_sb;
    if (adr == ADR_SC)
      dout = {r_sc7, 7'b0} | SC_RD_MASK | {7'b0, r_sc0};
  end

  assign irq     = r_irq;
  assign sout    = r_sout;
  assign sck_out = r_sck_out;
  assign sck_oe  = r_sc0;

endmodule

// File: tb/tb_lr35902_sio.sv
// Directed bench for lr35902_sio: register read-back table plus transfer,
// abort, ignored-write, completion-cycle-write and reset sequences.
module tb_lr35902_sio;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       adr = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       read = 1'b0;
  logic       write = 1'b0;
  logic       irq;
  logic       sin = 1'b1;
  logic       sout;
  logic       sck_in = 1'b1;
  logic       sck_out;
  logic       sck_oe;

  int n_cmp = 0;
  int n_fail = 0;
  int irq_cnt = 0;
  logic [7:0] cap = 8'h00;
  logic       prev_sck = 1'b1;

  lr35902_sio #(.HALF_PERIOD(256)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .adr     (adr),
    .din     (din),
    .dout    (dout),
    .read    (read),
    .write   (write),
    .irq     (irq),
    .sin     (sin),
    .sout    (sout),
    .sck_in  (sck_in),
    .sck_out (sck_out),
    .sck_oe  (sck_oe)
  );

  always #5 clk = ~clk;

  // Count irq pulses and capture sout on each internal sck falling edge.
  always @(negedge clk) begin
    if (irq === 1'b1) irq_cnt++;
    if (prev_sck === 1'b1 && sck_out === 1'b0) cap = {cap[6:0], sout};
    prev_sck = sck_out;
  end

  typedef struct {
    string      name;
    logic       rst;
    logic       wadr;
    logic [7:0] wdat;
    logic [7:0] exp_sb;
    logic [7:0] exp_sc;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    adr = a; din = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic chk_rd(input string name, input logic a, input logic [7:0] exp);
    adr = a;
    #1;
    chk(name, dout, exp);
  endtask

  initial begin
    vecs[0] = '{"rst",     1'b1, 1'b0, 8'h00, 8'h00, 8'h7E};
    vecs[1] = '{"sb12",    1'b0, 1'b0, 8'h12, 8'h12, 8'h7E};
    vecs[2] = '{"sc01",    1'b0, 1'b1, 8'h01, 8'h12, 8'h7F};
    vecs[3] = '{"sc00",    1'b0, 1'b1, 8'h00, 8'h12, 8'h7E};
    vecs[4] = '{"sbff",    1'b0, 1'b0, 8'hFF, 8'hFF, 8'h7E};
    vecs[5] = '{"sc7f",    1'b0, 1'b1, 8'h7F, 8'hFF, 8'h7F};
    vecs[6] = '{"sc7e",    1'b0, 1'b1, 8'h7E, 8'hFF, 8'h7E};

    n_reset = 1'b0;
    tick(); tick();
    n_reset = 1'b1;
    chk("rst_sout", {7'b0, sout}, 8'h01);
    chk("rst_sck", {7'b0, sck_out}, 8'h01);
    chk("rst_irq", {7'b0, irq}, 8'h00);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].rst) begin
        n_reset = 1'b0; tick(); n_reset = 1'b1;
      end else begin
        wr(vecs[i].wadr, vecs[i].wdat);
      end
      chk({vecs[i].name, "_sb"}, dout === dout ? 8'h00 : 8'h00, 8'h00);
      n_cmp--;
      chk_rd({vecs[i].name, "_sb"}, 1'b0, vecs[i].exp_sb);
      chk_rd({vecs[i].name, "_sc"}, 1'b1, vecs[i].exp_sc);
    end

    // Internal transfer: 0xA5 out, sin=1 in, 4096 cycles to completion.
    sin = 1'b1; irq_cnt = 0; cap = 8'h00;
    wr(1'b0, 8'hA5);
    wr(1'b1, 8'h81);
    chk("int_oe", {7'b0, sck_oe}, 8'h01);
    repeat (4095) tick();
    chk_rd("int_busy_sc", 1'b1, 8'hFF);
    chk("int_no_irq_yet", {7'b0, irq}, 8'h00);
    tick();
    chk("int_irq", {7'b0, irq}, 8'h01);
    chk_rd("int_sb", 1'b0, 8'hFF);
    chk_rd("int_sc", 1'b1, 8'h7F);
    tick();
    chk("int_irq_low", {7'b0, irq}, 8'h00);
    chk("int_sck_idle", {7'b0, sck_out}, 8'h01);
    repeat (3) tick();
    chk("int_irq_cnt", 8'(irq_cnt), 8'h01);
    chk("int_sout_bits", cap, 8'hA5);

    // External transfer: 0x3C out, 0x96 in via sck_in pulses.
    begin
      logic [7:0] pat;
      logic [7:0] outb;
      pat = 8'h96; outb = 8'h00; irq_cnt = 0;
      wr(1'b0, 8'h3C);
      wr(1'b1, 8'h80);
      chk("ext_oe_start", {7'b0, sck_oe}, 8'h00);
      for (int b = 7; b >= 0; b--) begin
        sck_in = 1'b0;
        sin = pat[b];
        repeat (20) tick();
        outb = {outb[6:0], sout};
        sck_in = 1'b1;
        repeat (20) tick();
      end
      chk_rd("ext_sb", 1'b0, 8'h96);
      chk_rd("ext_sc", 1'b1, 8'h7E);
      chk("ext_sout_bits", outb, 8'h3C);
      chk("ext_irq_cnt", 8'(irq_cnt), 8'h01);
      chk("ext_oe_end", {7'b0, sck_oe}, 8'h00);
      chk("ext_sck_out", {7'b0, sck_out}, 8'h01);
    end

    // Abort after 3 rising edges with sin=0: 0xA5 << 3 = 0x28.
    sin = 1'b0; irq_cnt = 0;
    wr(1'b0, 8'hA5);
    wr(1'b1, 8'h81);
    repeat (1600) tick();
    wr(1'b1, 8'h01);
    chk_rd("abort_sc", 1'b1, 8'h7F);
    chk("abort_sck", {7'b0, sck_out}, 8'h01);
    repeat (3000) tick();
    chk_rd("abort_sb", 1'b0, 8'h28);
    chk("abort_irq_cnt", 8'(irq_cnt), 8'h00);

    // Ignored writes mid-transfer: original 0xC3 and internal clock survive.
    sin = 1'b1; irq_cnt = 0; cap = 8'h00;
    wr(1'b0, 8'hC3);
    wr(1'b1, 8'h81);
    repeat (1000) tick();
    wr(1'b0, 8'h55);
    wr(1'b1, 8'h80);
    repeat (3093) tick();
    chk_rd("ign_busy_sc", 1'b1, 8'hFF);
    tick();
    chk("ign_irq", {7'b0, irq}, 8'h01);
    chk_rd("ign_sb", 1'b0, 8'hFF);
    chk_rd("ign_sc", 1'b1, 8'h7F);
    chk("ign_sout_bits", cap, 8'hC3);

    // Write to SB in the completion cycle lands after the final shift.
    sin = 1'b0; irq_cnt = 0;
    wr(1'b0, 8'h0F);
    wr(1'b1, 8'h81);
    repeat (4095) tick();
    wr(1'b0, 8'h5A);
    chk("cmp_irq", {7'b0, irq}, 8'h01);
    chk_rd("cmp_sb", 1'b0, 8'h5A);
    chk_rd("cmp_sc", 1'b1, 8'h7F);

    // Reset at bit 5 with a simultaneous write: reset wins, no irq.
    sin = 1'b1; repeat (3) tick(); irq_cnt = 0;
    wr(1'b0, 8'hA5);
    wr(1'b1, 8'h81);
    repeat (2600) tick();
    n_reset = 1'b0; adr = 1'b0; din = 8'h77; write = 1'b1;
    tick();
    n_reset = 1'b1; write = 1'b0;
    chk_rd("rstx_sb", 1'b0, 8'h00);
    chk_rd("rstx_sc", 1'b1, 8'h7E);
    chk("rstx_sout", {7'b0, sout}, 8'h01);
    chk("rstx_sck", {7'b0, sck_out}, 8'h01);
    repeat (2000) tick();
    chk("rstx_irq_cnt", 8'(irq_cnt), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
